// File: rtl/seq_detect_pkg.sv
// Shared types, reset constants and helpers for the programmable sequence detector.
// Helpers are sized for patterns up to MAX_PAT_W bits.
package seq_detect_pkg;

    localparam int unsigned MAX_PAT_W = 64;

    localparam logic [MAX_PAT_W-1:0] DEFAULT_MASK    = '1;
    localparam logic                 DEFAULT_OVERLAP = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        FILLING,
        ARMED
    } detState_t;

    function automatic int unsigned clampLen(input int unsigned len, input int unsigned maxLen);
        if (len == 0)
            return 1;
        else if (len > maxLen)
            return maxLen;
        else
            return len;
    endfunction

    // Low 'len' bits set; selects the history bits that belong to the active pattern.
    function automatic logic [MAX_PAT_W-1:0] lenMaskOf(input int unsigned len);
        logic [MAX_PAT_W-1:0] one;
        one = 1;
        if (len >= MAX_PAT_W)
            return '1;
        else
            return (one << len) - one;
    endfunction

endpackage

// File: rtl/seq_detect_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones.
module seq_detect_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != '1))
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with masking and overlap control.
// Define SEQ_DETECT_MATCH_COUNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter  int PAT_W = 16,
    parameter  int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] msk_q, msk_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             match_q, match_d;
    detState_t        state_q, state_d;

    logic             accept;
    logic             hit;
    logic [PAT_W-1:0] histShift;
    logic [LEN_W-1:0] fillInc;
    logic [PAT_W-1:0] lenMask;

    assign accept    = in_valid && !cfg_load;
    assign histShift = {hist_q[PAT_W-2:0], in_bit};
    assign fillInc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
    assign lenMask   = PAT_W'(lenMaskOf(32'(len_q)));

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            msk_q   <= PAT_W'(DEFAULT_MASK);
            len_q   <= LEN_W'(PAT_W);
            ovl_q   <= DEFAULT_OVERLAP;
            match_q <= 1'b0;
            state_q <= IDLE;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            msk_q   <= msk_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
            state_q <= state_d;
        end
    end

    // A non-overlapping hit empties the fill so the next match needs len fresh bits.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        msk_d   = msk_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        match_d = 1'b0;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            msk_d  = cfg_mask;
            len_d  = LEN_W'(clampLen(32'(cfg_len), PAT_W));
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d  = histShift;
            fill_d  = (hit && !ovl_q) ? '0 : fillInc;
            match_d = hit;
        end

        if (fill_d == '0)
            state_d = IDLE;
        else if (fill_d < len_d)
            state_d = FILLING;
        else
            state_d = ARMED;
    end

    always_comb begin
        hit = accept
              && ((state_q == ARMED) || (fillInc >= len_q))
              && (((histShift ^ pat_q) & msk_q & lenMask) == '0);
    end

    assign match = match_q;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
    seq_detect_sat_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cfg_load),
        .inc  (hit),
        .count(match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule
